// File: rtl/fp_unpack_pipe.sv
// Two-stage pipelined IEEE-754 operand unpacker with valid/ready flow control.
// S1 decodes fields and rebiases singles; S2 counts leading zeros and normalises.
module fp_unpack_pipe #(
    parameter int EW  = 11,
    parameter int FW  = 52,
    parameter int SEW = 8,
    parameter int SFW = 23,
    parameter int LZW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   fp,
    input  logic          db,
    input  logic          normal,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          s,
    output logic [EW:0]   e,
    output logic [LZW-1:0] lz,
    output logic [FW:0]   f,
    output logic          fz,
    output logic [FW-1:0] h,
    output logic          e_inf,
    output logic          e_z,
    output logic          is_zero,
    output logic          is_inf,
    output logic          is_nan,
    output logic          is_snan,
    output logic          is_denorm
);

    localparam int DBIAS = 2 ** (EW - 1) - 1;
    localparam int SBIAS = 2 ** (SEW - 1) - 1;
    localparam logic [EW:0] E_MAX    = {1'b0, {EW{1'b1}}};
    localparam logic [EW:0] S_REBIAS = (EW + 1)'(DBIAS - SBIAS);
    localparam logic [EW:0] S_DEN_E  = (EW + 1)'(DBIAS - SBIAS + 1);

    // Valid/ready: a beat moves on a stage boundary when the producer's valid and
    // the consumer's ready are both high at the clock edge. A stage may load when
    // it is empty or its content leaves in the same cycle, so in_ready depends
    // combinationally on out_ready. Data held in S2 never changes while stalled.
    logic v1, v2;
    logic adv1, adv2;

    assign adv2      = !v2 || out_ready;
    assign adv1      = !v1 || adv2;
    assign in_ready  = adv1;
    assign out_valid = v2;

    // S1 decode
    logic [EW-1:0]  dexp;
    logic [SEW-1:0] sexp;
    logic           d_ez, d_einf, d_fz;
    logic [FW-1:0]  d_h;
    logic [EW:0]    d_e;

    assign dexp = fp[62 -: EW];
    assign sexp = fp[62 -: SEW];

    always_comb begin
        d_ez   = db ? (dexp == '0) : (sexp == '0);
        d_einf = db ? (&dexp) : (&sexp);
        d_h    = db ? fp[FW-1:0] : {fp[62-SEW -: SFW], {(FW - SFW){1'b0}}};
        d_fz   = (d_h == '0);
        if (d_einf)
            d_e = E_MAX;
        else if (d_ez)
            d_e = d_fz ? '0 : (db ? (EW + 1)'(1) : S_DEN_E);
        else
            d_e = db ? {1'b0, dexp} : (EW + 1)'(sexp) + S_REBIAS;
    end

    logic          s1_s, s1_nrm, s1_ez, s1_einf, s1_fz;
    logic [EW:0]   s1_e;
    logic [FW-1:0] s1_h;

    // S2 leading-zero count and normalising shift
    function automatic logic [LZW-1:0] clz(input logic [FW:0] v);
        logic [LZW-1:0] n;
        logic           done;
        n    = '0;
        done = 1'b0;
        for (int i = FW; i >= 0; i--) begin
            if (!done) begin
                if (v[i]) done = 1'b1;
                else      n = n + LZW'(1);
            end
        end
        return n;
    endfunction

    logic           s1_den, do_norm;
    logic [FW:0]    f1, n_f;
    logic [LZW-1:0] n_lz;
    logic [EW:0]    n_e;

    always_comb begin
        s1_den  = s1_ez && !s1_fz;
        do_norm = s1_nrm && s1_den;
        f1      = {!s1_ez, s1_h};
        // Only denormals can carry leading zeros worth reporting; zero reports 0.
        n_lz    = s1_den ? clz(f1) : '0;
        n_f     = do_norm ? (f1 << n_lz) : f1;
        n_e     = do_norm ? (s1_e - (EW + 1)'(n_lz)) : s1_e;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1        <= 1'b0;
            v2        <= 1'b0;
            s1_s      <= 1'b0;
            s1_nrm    <= 1'b0;
            s1_ez     <= 1'b0;
            s1_einf   <= 1'b0;
            s1_fz     <= 1'b0;
            s1_e      <= '0;
            s1_h      <= '0;
            s         <= 1'b0;
            e         <= '0;
            lz        <= '0;
            f         <= '0;
            fz        <= 1'b0;
            h         <= '0;
            e_inf     <= 1'b0;
            e_z       <= 1'b0;
            is_zero   <= 1'b0;
            is_inf    <= 1'b0;
            is_nan    <= 1'b0;
            is_snan   <= 1'b0;
            is_denorm <= 1'b0;
        end else begin
            if (adv1) begin
                v1 <= in_valid;
                if (in_valid) begin
                    s1_s    <= fp[63];
                    s1_nrm  <= normal;
                    s1_ez   <= d_ez;
                    s1_einf <= d_einf;
                    s1_fz   <= d_fz;
                    s1_e    <= d_e;
                    s1_h    <= d_h;
                end
            end
            if (adv2) begin
                v2 <= v1;
                if (v1) begin
                    s         <= s1_s;
                    e         <= n_e;
                    lz        <= n_lz;
                    f         <= n_f;
                    fz        <= s1_fz;
                    h         <= s1_h;
                    e_inf     <= s1_einf;
                    e_z       <= s1_ez;
                    is_zero   <= s1_ez && s1_fz;
                    is_inf    <= s1_einf && s1_fz;
                    is_nan    <= s1_einf && !s1_fz;
                    is_snan   <= s1_einf && !s1_fz && !s1_h[FW-1];
                    is_denorm <= s1_den;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_unpack_pipe.sv
// Bench for fp_unpack_pipe: directed literal cases, backpressure, reset mid-flight
// and randomized traffic scored against an arithmetic model of the unpacking rules.
module tb_fp_unpack_pipe;

    localparam int RW = 132;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, db, normal, out_valid, out_ready;
    logic [63:0] fp;
    logic        s, fz, e_inf, e_z, is_zero, is_inf, is_nan, is_snan, is_denorm;
    logic [11:0] e;
    logic [5:0]  lz;
    logic [52:0] f;
    logic [51:0] h;

    fp_unpack_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fp(fp), .db(db), .normal(normal), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .e(e), .lz(lz), .f(f), .fz(fz), .h(h),
        .e_inf(e_inf), .e_z(e_z), .is_zero(is_zero), .is_inf(is_inf),
        .is_nan(is_nan), .is_snan(is_snan), .is_denorm(is_denorm)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out    = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] act_v;

    assign act_v = {s, e, lz, f, fz, h, e_inf, e_z, is_zero, is_inf, is_nan, is_snan, is_denorm};

    function automatic logic [RW-1:0] pk(input logic ps, input logic [11:0] pe, input logic [5:0] plz,
                                         input logic [52:0] pf, input logic pfz, input logic [51:0] ph,
                                         input logic pei, input logic pez, input logic pzr,
                                         input logic pin, input logic pnn, input logic psn,
                                         input logic pdn);
        return {ps, pe, plz, pf, pfz, ph, pei, pez, pzr, pin, pnn, psn, pdn};
    endfunction

    // Reference: decode with integer arithmetic, normalise by doubling.
    function automatic logic [RW-1:0] model(input logic [63:0] x, input logic dbl, input logic nrm);
        int          ef, emax, ee, l;
        logic [51:0] hh;
        longint      sig, tmp;
        logic        ez, einf, fzv, isn;
        logic [11:0] e12;
        if (dbl) begin
            ef = int'(x[62:52]); emax = 2047; hh = x[51:0];
        end else begin
            ef = int'(x[62:55]); emax = 255; hh = {x[54:32], 29'd0};
        end
        ez   = (ef == 0);
        einf = (ef == emax);
        fzv  = (hh == 52'd0);
        if (einf)      ee = 2047;
        else if (!ez)  ee = dbl ? ef : ef - 127 + 1023;
        else if (fzv)  ee = 0;
        else           ee = dbl ? 1 : 1 - 127 + 1023;
        sig = longint'(hh);
        if (!ez) sig = sig + (longint'(1) << 52);
        l = 0;
        if (ez && !fzv) begin
            tmp = sig;
            while (tmp < (longint'(1) << 52)) begin
                tmp = tmp * 2;
                l++;
            end
            if (nrm) begin
                sig = tmp;
                ee  = ee - l;
            end
        end
        e12 = ee[11:0];
        isn = einf && !fzv;
        return pk(x[63], e12, 6'(l), sig[52:0], fzv, hh, einf, ez, ez && fzv, einf && fzv,
                  isn, isn && !hh[51], ez && !fzv);
    endfunction

    function automatic logic [63:0] rand_op(input logic dbl);
        int          k  = $urandom_range(0, 5);
        logic        sg = 1'($urandom);
        logic [63:0] fr = {$urandom, $urandom};
        int          ex;
        if (dbl) begin
            fr = fr & 64'h000F_FFFF_FFFF_FFFF;
            case (k)
                0: begin ex = 0; fr = 64'd0; end
                1: begin ex = 0; fr = fr >> $urandom_range(0, 51); if (fr == 64'd0) fr = 64'd1; end
                4: begin ex = 2047; fr = 64'd0; end
                5: begin ex = 2047; fr = fr >> $urandom_range(0, 51); if (fr == 64'd0) fr = 64'd1; end
                default: ex = $urandom_range(1, 2046);
            endcase
            return {sg, 11'(ex), fr[51:0]};
        end else begin
            fr = fr & 64'h0000_0000_007F_FFFF;
            case (k)
                0: begin ex = 0; fr = 64'd0; end
                1: begin ex = 0; fr = fr >> $urandom_range(0, 22); if (fr == 64'd0) fr = 64'd1; end
                4: begin ex = 255; fr = 64'd0; end
                5: begin ex = 255; fr = fr >> $urandom_range(0, 22); if (fr == 64'd0) fr = 64'd1; end
                default: ex = $urandom_range(1, 254);
            endcase
            return {sg, 8'(ex), fr[22:0], 32'($urandom)};
        end
    endfunction

    task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // One clock of stimulus; the scoreboard learns of an operand the moment it is accepted.
    task automatic step(input logic iv, input logic [63:0] x, input logic dbl, input logic nrm,
                        input logic ordy, output logic acc);
        @(negedge clk);
        in_valid  = iv;
        fp        = x;
        db        = dbl;
        normal    = nrm;
        out_ready = ordy;
        #1;
        acc = iv && in_ready && !rst;
        if (acc) exp_q.push_back(model(x, dbl, nrm));
    endtask

    task automatic run_directed(input string name, input logic [63:0] x, input logic dbl,
                                input logic nrm, input logic [RW-1:0] want);
        logic acc;
        check({name, "_model"}, model(x, dbl, nrm), want);
        step(1'b1, x, dbl, nrm, 1'b1, acc);
        check({name, "_accept"}, RW'(acc), RW'(1));
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, acc);
        check({name, "_lat1_valid"}, RW'(out_valid), RW'(0));
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, acc);
        check({name, "_lat2_valid"}, RW'(out_valid), RW'(1));
        check({name, "_fields"}, act_v, want);
    endtask

    // Compare process: scores every consumed result and checks stall stability.
    logic          held;
    logic [RW-1:0] held_val;

    initial begin
        held = 1'b0;
        held_val = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_stable", {out_valid, act_v}, {1'b1, held_val});
                end
                held = 1'b0;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out: got %h expected no result", act_v);
                    end else begin
                        check("scoreboard", act_v, exp_q.pop_front());
                    end
                    n_out++;
                end else if (out_valid) begin
                    held     = 1'b1;
                    held_val = act_v;
                end
            end
        end
    end

    initial begin
        logic        acc, have, pd, pn;
        logic [63:0] px;
        logic [63:0] bp[4];
        int          n0;

        rst = 1'b1; in_valid = 1'b0; fp = 64'd0; db = 1'b0; normal = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", RW'(out_valid), RW'(0));
        check("reset_outputs", act_v, '0);
        check("reset_in_ready", RW'(in_ready), RW'(1));

        run_directed("dbl_one", 64'h3FF0_0000_0000_0000, 1'b1, 1'b1,
                     pk(0, 12'h3FF, 6'd0, 53'h10_0000_0000_0000, 1, 52'd0, 0, 0, 0, 0, 0, 0, 0));
        run_directed("dbl_zero", 64'd0, 1'b1, 1'b1,
                     pk(0, 12'h000, 6'd0, 53'd0, 1, 52'd0, 0, 1, 1, 0, 0, 0, 0));
        run_directed("dbl_den_norm", 64'd1, 1'b1, 1'b1,
                     pk(0, 12'hFCD, 6'd52, 53'h10_0000_0000_0000, 0, 52'd1, 0, 1, 0, 0, 0, 0, 1));
        run_directed("dbl_den_raw", 64'd1, 1'b1, 1'b0,
                     pk(0, 12'h001, 6'd52, 53'd1, 0, 52'd1, 0, 1, 0, 0, 0, 0, 1));
        run_directed("sgl_minus_one", 64'hBF80_0000_0000_0000, 1'b0, 1'b1,
                     pk(1, 12'h3FF, 6'd0, 53'h10_0000_0000_0000, 1, 52'd0, 0, 0, 0, 0, 0, 0, 0));
        run_directed("sgl_den_norm", 64'h0000_0001_DEAD_BEEF, 1'b0, 1'b1,
                     pk(0, 12'd874, 6'd23, 53'h10_0000_0000_0000, 0, 52'h2000_0000, 0, 1, 0, 0, 0, 0, 1));
        run_directed("sgl_inf", 64'h7F80_0000_0000_0000, 1'b0, 1'b1,
                     pk(0, 12'h7FF, 6'd0, 53'h10_0000_0000_0000, 1, 52'd0, 1, 0, 0, 1, 0, 0, 0));
        run_directed("dbl_snan", 64'h7FF0_0000_0000_0001, 1'b1, 1'b1,
                     pk(0, 12'h7FF, 6'd0, 53'h10_0000_0000_0001, 0, 52'd1, 1, 0, 0, 0, 1, 1, 0));
        run_directed("dbl_qnan", 64'h7FF8_0000_0000_0000, 1'b1, 1'b1,
                     pk(0, 12'h7FF, 6'd0, 53'h18_0000_0000_0000, 0, 52'h8_0000_0000_0000, 1, 0, 0, 0, 1, 0, 0));

        // Backpressure: out_ready low for three cycles while four operands are offered.
        for (int i = 0; i < 4; i++) bp[i] = rand_op(1'($urandom));
        step(1'b1, bp[0], 1'b1, 1'b1, 1'b0, acc);
        check("bp_accept0", RW'(acc), RW'(1));
        step(1'b1, bp[1], 1'b1, 1'b1, 1'b0, acc);
        check("bp_accept1", RW'(acc), RW'(1));
        step(1'b1, bp[2], 1'b1, 1'b1, 1'b0, acc);
        check("bp_in_ready_low", RW'(in_ready), RW'(0));
        check("bp_out_valid", RW'(out_valid), RW'(1));
        n0 = n_out;
        step(1'b1, bp[2], 1'b1, 1'b1, 1'b1, acc);
        check("bp_accept2", RW'(acc), RW'(1));
        step(1'b1, bp[3], 1'b1, 1'b1, 1'b1, acc);
        check("bp_accept3", RW'(acc), RW'(1));
        repeat (3) step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, acc);
        check("bp_no_gaps", RW'(n_out - n0), RW'(4));
        check("bp_drained", RW'(out_valid), RW'(0));

        // Reset with both stages occupied.
        step(1'b1, rand_op(1'b1), 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, rand_op(1'b0), 1'b0, 1'b1, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_out_valid", RW'(out_valid), RW'(0));
        check("rst_mid_outputs", act_v, '0);
        check("rst_mid_in_ready", RW'(in_ready), RW'(1));
        run_directed("post_rst_sgl_den", 64'h0000_0001_0000_0000, 1'b0, 1'b1,
                     pk(0, 12'd874, 6'd23, 53'h10_0000_0000_0000, 0, 52'h2000_0000, 0, 1, 0, 0, 0, 0, 1));

        // Randomized traffic with random stalls on both sides.
        have = 1'b0; px = 64'd0; pd = 1'b1; pn = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                pd   = 1'($urandom);
                pn   = 1'($urandom);
                px   = rand_op(pd);
                have = 1'b1;
            end
            step(have, px, pd, pn, 1'($urandom_range(0, 9) < 7), acc);
            if (acc) have = 1'b0;
        end

        for (int i = 0; i < 20 && exp_q.size() != 0; i++)
            step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, acc);
        step(1'b0, 64'd0, 1'b1, 1'b0, 1'b1, acc);
        check("final_queue_empty", RW'(exp_q.size()), RW'(0));
        check("final_out_valid", RW'(out_valid), RW'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
